// File: rtl/input_port.sv
// input_port: synchronized, debounced pushbutton plus switch byte
// with an enter/take producer handshake toward the control unit.
module input_port #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       keyRaw,
  input  logic [7:0] swRaw,
  input  logic       take,
  output logic [7:0] dataIn,
  output logic       enter,
  output logic       overrun,
  output logic       pressed
);

  // bit 1 of the state is the debounced level, so pressed is a flop
  localparam logic [1:0] RELEASED     = 2'b00;
  localparam logic [1:0] PRESS_PEND   = 2'b01;
  localparam logic [1:0] PRESSED      = 2'b10;
  localparam logic [1:0] RELEASE_PEND = 2'b11;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             key_s1_q, key_s2_q;
  logic [7:0]       sw_s1_q, sw_s2_q;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_evt;
  logic [7:0]       data_q, data_d;
  logic             enter_q, enter_d;
  logic             ovr_q, ovr_d;

  // two-flop synchronizers; key idles high (released)
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      key_s1_q <= 1'b1;
      key_s2_q <= 1'b1;
      sw_s1_q  <= 8'h00;
      sw_s2_q  <= 8'h00;
    end else begin
      key_s1_q <= keyRaw;
      key_s2_q <= key_s1_q;
      sw_s1_q  <= swRaw;
      sw_s2_q  <= sw_s1_q;
    end
  end

  // debounce: the first mismatching cycle counts as 1, event on the last
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_evt = 1'b0;
    unique case (state_q)
      RELEASED: begin
        if (!key_s2_q) begin
          state_d = PRESS_PEND;
          cnt_d   = CNT_ONE;
        end
      end
      PRESS_PEND: begin
        if (key_s2_q) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = PRESSED;
          cnt_d     = '0;
          press_evt = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PRESSED: begin
        if (key_s2_q) begin
          state_d = RELEASE_PEND;
          cnt_d   = CNT_ONE;
        end
      end
      RELEASE_PEND: begin
        if (!key_s2_q) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

  // debounce state and counter registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= RELEASED;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // handshake: first pending byte wins unless consumed in the same cycle
  always_comb begin
    data_d  = data_q;
    enter_d = enter_q;
    ovr_d   = ovr_q;
    if (press_evt) begin
      if (!enter_q || take) begin
        data_d  = sw_s2_q;
        enter_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (take && enter_q) begin
      enter_d = 1'b0;
    end
  end

  // handshake output registers; overrun is sticky until reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data_q  <= 8'h00;
      enter_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      enter_q <= enter_d;
      ovr_q   <= ovr_d;
    end
  end

  assign dataIn  = data_q;
  assign enter   = enter_q;
  assign overrun = ovr_q;
  assign pressed = state_q[1];

endmodule

// File: tb/tb_input_port.sv
// tb_input_port: directed vectors, scoreboard on the handshake outputs
// plus direct timing checks on edges called out for the port.
module tb_input_port;

  localparam int D = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic       keyRaw;
  logic [7:0] swRaw;
  logic       take;
  logic [7:0] dataIn;
  logic       enter;
  logic       overrun;
  logic       pressed;

  typedef struct packed {
    logic [7:0] d;
    logic       e;
    logic       o;
  } snap_t;

  snap_t exp_q[$];
  snap_t prev;
  snap_t cur;
  snap_t expv;
  bit    mon_en = 1'b0;
  int    vectors = 0;
  int    miscompares = 0;

  input_port #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .clock  (clock),
    .reset  (reset),
    .keyRaw (keyRaw),
    .swRaw  (swRaw),
    .take   (take),
    .dataIn (dataIn),
    .enter  (enter),
    .overrun(overrun),
    .pressed(pressed)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic push(input logic [7:0] d, input logic e,
                      input logic o);
    snap_t s;
    s.d = d;
    s.e = e;
    s.o = o;
    exp_q.push_back(s);
  endtask

  task automatic release_key();
    keyRaw = 1'b1;
    cyc(8);
    chk("release_pressed", {31'd0, pressed}, 32'd0);
  endtask

  // monitor: every change of the handshake outputs must match the queue
  always @(negedge clock) begin
    if (mon_en) begin
      cur = {dataIn, enter, overrun};
      if (cur !== prev) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL sb_unexpected: got d=%0h e=%0b o=%0b want none",
                   cur.d, cur.e, cur.o);
        end else begin
          expv = exp_q.pop_front();
          if (cur !== expv) begin
            miscompares++;
            $display("FAIL sb_cmp: got d=%0h e=%0b o=%0b want d=%0h e=%0b o=%0b",
                     cur.d, cur.e, cur.o, expv.d, expv.e, expv.o);
          end
        end
        prev = cur;
      end
    end
  end

  initial begin
    reset  = 1'b0;
    keyRaw = 1'b1;
    swRaw  = 8'h00;
    take   = 1'b0;
    cyc(3);
    chk("rst_data", {24'd0, dataIn}, 32'h00);
    chk("rst_enter", {31'd0, enter}, 32'd0);
    chk("rst_ovr", {31'd0, overrun}, 32'd0);
    chk("rst_pressed", {31'd0, pressed}, 32'd0);
    reset  = 1'b1;
    prev   = '0;
    mon_en = 1'b1;
    cyc(2);

    // clean press: edge 0 is the next posedge
    swRaw  = 8'hA5;
    keyRaw = 1'b0;
    push(8'hA5, 1'b1, 1'b0);
    cyc(D + 1);
    chk("clean_enter_early", {31'd0, enter}, 32'd0);
    chk("clean_pressed_early", {31'd0, pressed}, 32'd0);
    cyc(1);
    chk("clean_enter", {31'd0, enter}, 32'd1);
    chk("clean_data", {24'd0, dataIn}, 32'hA5);
    chk("clean_pressed", {31'd0, pressed}, 32'd1);
    take = 1'b1;
    push(8'hA5, 1'b0, 1'b0);
    cyc(1);
    take = 1'b0;
    chk("clean_take", {31'd0, enter}, 32'd0);
    release_key();

    // bounce: low 3 edges, high 1, then low from edge 4
    swRaw  = 8'h3C;
    keyRaw = 1'b0;
    push(8'h3C, 1'b1, 1'b0);
    cyc(3);
    keyRaw = 1'b1;
    cyc(1);
    keyRaw = 1'b0;
    cyc(D + 1);
    chk("bounce_enter_early", {31'd0, enter}, 32'd0);
    cyc(1);
    chk("bounce_enter", {31'd0, enter}, 32'd1);
    chk("bounce_data", {24'd0, dataIn}, 32'h3C);

    // handshake
    take = 1'b1;
    push(8'h3C, 1'b0, 1'b0);
    cyc(1);
    take = 1'b0;
    chk("hs_enter", {31'd0, enter}, 32'd0);
    chk("hs_data", {24'd0, dataIn}, 32'h3C);
    take = 1'b1;
    cyc(1);
    take = 1'b0;
    cyc(1);
    chk("hs_idle_enter", {31'd0, enter}, 32'd0);
    chk("hs_idle_data", {24'd0, dataIn}, 32'h3C);
    release_key();

    // simultaneous take and press event
    swRaw  = 8'h11;
    keyRaw = 1'b0;
    push(8'h11, 1'b1, 1'b0);
    cyc(D + 2);
    release_key();
    swRaw  = 8'h22;
    keyRaw = 1'b0;
    cyc(D + 1);
    take = 1'b1;
    push(8'h22, 1'b1, 1'b0);
    cyc(1);
    take = 1'b0;
    chk("sim_data", {24'd0, dataIn}, 32'h22);
    chk("sim_enter", {31'd0, enter}, 32'd1);
    chk("sim_ovr", {31'd0, overrun}, 32'd0);
    take = 1'b1;
    push(8'h22, 1'b0, 1'b0);
    cyc(1);
    take = 1'b0;
    release_key();

    // overrun: second press with no take
    swRaw  = 8'h11;
    keyRaw = 1'b0;
    push(8'h11, 1'b1, 1'b0);
    cyc(D + 2);
    release_key();
    swRaw  = 8'h22;
    keyRaw = 1'b0;
    push(8'h11, 1'b1, 1'b1);
    cyc(D + 2);
    chk("ovr_flag", {31'd0, overrun}, 32'd1);
    chk("ovr_data", {24'd0, dataIn}, 32'h11);
    chk("ovr_enter", {31'd0, enter}, 32'd1);
    take = 1'b1;
    push(8'h11, 1'b0, 1'b1);
    cyc(1);
    take = 1'b0;
    chk("ovr_sticky", {31'd0, overrun}, 32'd1);
    chk("ovr_take_enter", {31'd0, enter}, 32'd0);
    release_key();

    // reset mid-count in PRESS_PEND, key held through release
    swRaw  = 8'h5A;
    keyRaw = 1'b0;
    cyc(3);
    #2 reset = 1'b0;
    push(8'h00, 1'b0, 1'b0);
    #1;
    chk("rst1_data", {24'd0, dataIn}, 32'h00);
    chk("rst1_ovr", {31'd0, overrun}, 32'd0);
    chk("rst1_pressed", {31'd0, pressed}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    push(8'h5A, 1'b1, 1'b0);
    cyc(D);
    chk("refill_early", {31'd0, enter}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      if (!enter) cyc(1);
    end
    chk("refill_enter", {31'd0, enter}, 32'd1);
    chk("refill_data", {24'd0, dataIn}, 32'h5A);

    // reset with a byte pending
    #2 reset = 1'b0;
    push(8'h00, 1'b0, 1'b0);
    #1;
    chk("rst2_enter", {31'd0, enter}, 32'd0);
    chk("rst2_data", {24'd0, dataIn}, 32'h00);
    chk("rst2_pressed", {31'd0, pressed}, 32'd0);
    keyRaw = 1'b1;
    @(negedge clock);
    reset = 1'b1;
    cyc(8);
    chk("end_pressed", {31'd0, pressed}, 32'd0);
    chk("end_enter", {31'd0, enter}, 32'd0);
    chk("sb_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
